// File: rtl/mul_ctrl.sv
// mul_ctrl: runs one M-extension multiply at a time through the 34-cycle Booth
// multiplier, formats the 64-bit result and returns it over a valid/ready port.
module mul_ctrl #(
    parameter bit FAST_ZERO = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [2:0]   req_op,
    input  logic [63:0]  req_rs1,
    input  logic [63:0]  req_rs2,
    input  logic         flush,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic [63:0]  resp_data,
    output logic         mul_valid,
    output logic         mul_rs1_sign,
    output logic         mul_rs2_sign,
    output logic [63:0]  mul_rs1_data,
    output logic [63:0]  mul_rs2_data,
    input  logic         mul_ready,
    input  logic [127:0] mul_result
);

    typedef enum logic [1:0] {IDLE, BUSY, DRAIN, DONE} state_t;
    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_MULW   = 3'b100
    } op_t;

    state_t      state_q;
    op_t         op_q;
    op_t         op_d;
    logic        reqReady_q;
    logic        respValid_q;
    logic        mulValid_q;
    logic        rs1Sign_q;
    logic        rs2Sign_q;
    logic        rs1Sign_d;
    logic        rs2Sign_d;
    logic [63:0] respData_q;
    logic [63:0] rs1Data_q;
    logic [63:0] rs2Data_q;
    logic [63:0] rs1Data_d;
    logic [63:0] rs2Data_d;
    logic [63:0] result_d;
    logic        zeroOperand_d;

    // Unused encodings 101-111 fall through to plain MUL.
    always_comb begin
        op_d          = OP_MUL;
        rs1Data_d     = req_rs1;
        rs2Data_d     = req_rs2;
        rs1Sign_d     = 1'b1;
        rs2Sign_d     = 1'b1;
        zeroOperand_d = (req_rs1 == 64'd0) || (req_rs2 == 64'd0);
        case (req_op)
            3'b001: op_d = OP_MULH;
            3'b010: begin
                op_d      = OP_MULHSU;
                rs2Sign_d = 1'b0;
            end
            3'b011: begin
                op_d      = OP_MULHU;
                rs1Sign_d = 1'b0;
                rs2Sign_d = 1'b0;
            end
            3'b100: begin
                op_d          = OP_MULW;
                rs1Data_d     = {{32{req_rs1[31]}}, req_rs1[31:0]};
                rs2Data_d     = {{32{req_rs2[31]}}, req_rs2[31:0]};
                zeroOperand_d = (req_rs1[31:0] == 32'd0) || (req_rs2[31:0] == 32'd0);
            end
            default: ;
        endcase
    end

    always_comb begin
        result_d = mul_result[63:0];
        case (op_q)
            OP_MULH, OP_MULHSU, OP_MULHU: result_d = mul_result[127:64];
            OP_MULW: result_d = {{32{mul_result[31]}}, mul_result[31:0]};
            default: ;
        endcase
    end

    // mul_valid must stay high through DRAIN: the multiplier only counts while
    // valid, so dropping it early would leave a stale count for the next op.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= OP_MUL;
            reqReady_q  <= 1'b1;
            respValid_q <= 1'b0;
            respData_q  <= 64'd0;
            mulValid_q  <= 1'b0;
            rs1Sign_q   <= 1'b0;
            rs2Sign_q   <= 1'b0;
            rs1Data_q   <= 64'd0;
            rs2Data_q   <= 64'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid && !flush) begin
                        op_q       <= op_d;
                        rs1Data_q  <= rs1Data_d;
                        rs2Data_q  <= rs2Data_d;
                        rs1Sign_q  <= rs1Sign_d;
                        rs2Sign_q  <= rs2Sign_d;
                        reqReady_q <= 1'b0;
                        if (FAST_ZERO && zeroOperand_d) begin
                            respData_q  <= 64'd0;
                            respValid_q <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            mulValid_q <= 1'b1;
                            state_q    <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (mul_ready) begin
                        mulValid_q <= 1'b0;
                        if (flush) begin
                            reqReady_q <= 1'b1;
                            state_q    <= IDLE;
                        end else begin
                            respData_q  <= result_d;
                            respValid_q <= 1'b1;
                            state_q     <= DONE;
                        end
                    end else if (flush) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (mul_ready) begin
                        mulValid_q <= 1'b0;
                        reqReady_q <= 1'b1;
                        state_q    <= IDLE;
                    end
                end
                DONE: begin
                    if (flush || resp_ready) begin
                        respValid_q <= 1'b0;
                        reqReady_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready    = reqReady_q;
    assign resp_valid   = respValid_q && !flush;
    assign resp_data    = respData_q;
    assign mul_valid    = mulValid_q;
    assign mul_rs1_sign = rs1Sign_q;
    assign mul_rs2_sign = rs2Sign_q;
    assign mul_rs1_data = rs1Data_q;
    assign mul_rs2_data = rs2Data_q;

endmodule

// File: doc/mul_ctrl.md
Name: mul_ctrl

Overview:
Sequencing controller between the execute stage and the 34-cycle radix-4 Booth multiplier. Accepts M-extension multiply ops (MUL, MULH, MULHSU, MULHU, MULW) over a valid/ready request port. Prepares operand signedness and holds the multiplier's valid for the whole operation. Selects and formats the 64-bit result and returns it over a valid/ready response port. Handles pipeline flush safely, since the multiplier cannot be aborted except by reset.

Parameters:
FAST_ZERO, 1, when 1 a zero operand completes without using the multiplier (result 0, 1-cycle latency)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  request valid
req_ready  out  1  controller can accept a request
req_op  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 MULW, 101-111 treated as MUL
req_rs1  in  64  operand 1
req_rs2  in  64  operand 2
flush  in  1  kill the in-flight operation / pending response
resp_valid  out  1  result valid
resp_ready  in  1  consumer accepts result
resp_data  out  64  result
mul_valid  out  1  to multiplier valid; must be held until mul_ready
mul_rs1_sign  out  1  treat rs1 as signed
mul_rs2_sign  out  1  treat rs2 as signed
mul_rs1_data  out  64  multiplier operand 1
mul_rs2_data  out  64  multiplier operand 2
mul_ready  in  1  multiplier done (one-cycle pulse)
mul_result  in  128  full product

Behaviour:
- Single clock clk. Reset is synchronous and active-high on rst; the multiplier shares rst.
- Reset values:
  - state=IDLE, req_ready=1, resp_valid=0, resp_data=0, mul_valid=0.
  - mul_rs*_sign=0, mul_rs*_data=0, kill flag=0.
- States: IDLE, BUSY, DRAIN, DONE.
- IDLE:
  - req_ready=1.
  - Request accepted on req_valid & ~flush; req_valid with flush high is ignored.
  - On accept, latch op and operands into mul_rs* registers.
  - If FAST_ZERO and an effective operand is zero: resp_data<=0, go to DONE. For MULW the effective operand is bits [31:0]; otherwise the full 64 bits.
  - Otherwise go to BUSY.
- Operand prep:
  - MUL: signs 1/1.
  - MULH: 1/1.
  - MULHSU: 1/0.
  - MULHU: 0/0.
  - MULW: both operands sign-extended from bit 31, signs 1/1.
- BUSY:
  - mul_valid=1, req_ready=0. Operand and sign outputs stay stable.
  - On mul_ready & ~flush, latch the result and go to DONE:
    - MUL: mul_result[63:0].
    - MULH, MULHSU, MULHU: mul_result[127:64].
    - MULW: sign-extend mul_result[31:0].
  - flush without mul_ready: go to DRAIN.
  - flush together with mul_ready: result discarded, go to IDLE.
- DRAIN:
  - mul_valid stays 1; the multiplier counter only advances while valid, so dropping valid would corrupt the next op.
  - req_ready=0, resp_valid=0.
  - On mul_ready go to IDLE. Further flushes have no effect.
- DONE:
  - resp_valid = ~flush (combinational mask).
  - resp_valid & resp_ready: go to IDLE.
  - flush: go to IDLE and drop the response. No handshake occurs in that cycle even if resp_ready=1.
  - resp_ready low: hold resp_data and resp_valid stable.
- mul_valid is never high outside BUSY/DRAIN. mul_ready seen outside BUSY/DRAIN is ignored.
- Latency, request accepted at cycle T (multiplier path):
  - mul_valid high T+1..T+34.
  - mul_ready at T+34.
  - resp_valid from T+35.
  - Next request accepted no earlier than T+36 with resp_ready=1, because a request is accepted only in IDLE.
- Fast-zero path: resp_valid at T+1.
- No back-to-back overlap: one operation in flight.
- Reset mid-operation (any state) returns to the reset values in the next cycle; no response is produced.

Test Plan:
- MUL 3×5, resp_ready=1, accepted at T → mul_valid T+1..T+34; resp_valid at T+35 with resp_data=0xF; req_ready=1 at T+36.
- rs1=0xFFFF_FFFF_FFFF_FFFF, rs2=2 with MULH / MULHSU / MULHU → resp_data 0xFFFF_FFFF_FFFF_FFFF / 0xFFFF_FFFF_FFFF_FFFF / 0x1; check mul_rs*_sign=1/1, 1/0, 0/0 respectively.
- MULW, rs1=0x1234_5678_7FFF_FFFF, rs2=0x2 → mul_rs1_data=0x0000_0000_7FFF_FFFF; resp_data=0xFFFF_FFFF_FFFF_FFFE.
- flush at T+10 during MUL 7×9 → mul_valid stays high through T+34; no resp_valid; req_ready=0 until T+35. New MUL 2×2 accepted at T+35 returns 4 at T+70.
- FAST_ZERO=1, MULHU rs1=0xABCD, rs2=0 → no mul_valid; resp_valid at T+1 with 0. Hold resp_ready=0 for 5 cycles → data and valid stable, then handshake and return to IDLE.
- DONE with flush=1 and resp_ready=1 in the same cycle → resp_valid=0 that cycle, IDLE next. rst asserted at T+20 of an op → next cycle IDLE, req_ready=1, mul_valid=0, no response.
